// File: rtl/window_pkg.sv
// Shared types and width helpers for the raster-to-window converter.
package window_pkg;

  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned DEF_FRAME_WIDTH  = 640;
  localparam int unsigned DEF_FRAME_HEIGHT = 480;
  localparam int unsigned COL_W = cnt_w(DEF_FRAME_WIDTH);
  localparam int unsigned ROW_W = cnt_w(DEF_FRAME_HEIGHT);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

endpackage

// File: rtl/window_generator_line_buffer.sv
// One line of pixel history: registered read, read-before-write on a shared address.
module line_buffer
  import window_pkg::*;
#(
  parameter int unsigned DATA_W = 12,
  parameter int unsigned DEPTH  = 640,
  localparam int unsigned ADDR_W = cnt_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
    if (wr_en) mem[wr_addr] <= wr_data;
  end

endmodule

// File: rtl/window_generator.sv
// Streaming raster-to-window converter: emits every fully populated
// WINDOW_SIZE x WINDOW_SIZE neighbourhood two cycles after its last pixel.
module window_generator
  import window_pkg::*;
#(
  parameter int unsigned PIX_DATA_W    = 12,
  parameter int unsigned WINDOW_SIZE   = 3,
  parameter int unsigned INPUTS_AMOUNT = WINDOW_SIZE**2,
  parameter int unsigned FRAME_WIDTH   = 640,
  parameter int unsigned FRAME_HEIGHT  = 480
) (
  input  logic                                    clk_i,
  input  logic                                    rst_i,
  input  logic                                    data_valid_i,
  input  logic                                    sof_i,
  input  logic [PIX_DATA_W-1:0]                   data_i,
  output logic                                    data_valid_o,
  output logic [INPUTS_AMOUNT-1:0][PIX_DATA_W-1:0] data_o,
  output logic                                    frame_err_o
);

  localparam int unsigned CW    = cnt_w(FRAME_WIDTH);
  localparam int unsigned RW    = cnt_w(FRAME_HEIGHT);
  localparam int unsigned LINES = WINDOW_SIZE - 1;

  typedef logic [INPUTS_AMOUNT-1:0][PIX_DATA_W-1:0] window_t;

  state_t          state, state_next;
  logic [CW-1:0]   col, col_next, pix_col;
  logic [RW-1:0]   row, row_next, pix_row;
  logic            accept, err_next, emit0;

  logic            s1_valid, s1_emit;
  logic [CW-1:0]   s1_col;
  logic [PIX_DATA_W-1:0] s1_pix;

  logic [PIX_DATA_W-1:0] lb_q    [LINES];
  logic [PIX_DATA_W-1:0] col_vec [WINDOW_SIZE];
  window_t         win_q, win_next;

  // sof always forces the accepted pixel to (0,0), whatever the counters say
  always_comb begin
    state_next = state;
    col_next   = col;
    row_next   = row;
    accept     = 1'b0;
    err_next   = 1'b0;
    pix_col    = sof_i ? '0 : col;
    pix_row    = sof_i ? '0 : row;
    case (state)
      IDLE: if (data_valid_i) begin
        if (sof_i) accept = 1'b1;
        else       err_next = 1'b1;
      end
      RUN: if (data_valid_i) begin
        accept   = 1'b1;
        err_next = sof_i;
      end
      default: ;
    endcase
    if (accept) begin
      state_next = RUN;
      if (pix_col == CW'(FRAME_WIDTH - 1)) begin
        col_next = '0;
        row_next = pix_row + RW'(1);
        if (pix_row == RW'(FRAME_HEIGHT - 1)) begin
          state_next = IDLE;
          row_next   = '0;
        end
      end else begin
        col_next = pix_col + CW'(1);
        row_next = pix_row;
      end
    end
  end

  assign emit0 = accept && (pix_row >= RW'(WINDOW_SIZE - 1)) &&
                 (pix_col >= CW'(WINDOW_SIZE - 1));

  // Chained lines get their data one cycle late, so they write at the stage-1 address
  for (genvar k = 0; k < LINES; k++) begin : g_line
    if (k == 0) begin : g_head
      line_buffer #(.DATA_W(PIX_DATA_W), .DEPTH(FRAME_WIDTH)) u_lb (
        .clk     (clk_i),
        .rd_en   (accept),
        .rd_addr (pix_col),
        .wr_en   (accept),
        .wr_addr (pix_col),
        .wr_data (data_i),
        .rd_data (lb_q[k])
      );
    end else begin : g_tail
      line_buffer #(.DATA_W(PIX_DATA_W), .DEPTH(FRAME_WIDTH)) u_lb (
        .clk     (clk_i),
        .rd_en   (accept),
        .rd_addr (pix_col),
        .wr_en   (s1_valid),
        .wr_addr (s1_col),
        .wr_data (lb_q[k-1]),
        .rd_data (lb_q[k])
      );
    end
  end

  always_comb begin
    for (int unsigned r = 0; r < LINES; r++) col_vec[r] = lb_q[LINES-1-r];
    col_vec[LINES] = s1_pix;
  end

  always_comb begin
    win_next = win_q;
    for (int unsigned r = 0; r < WINDOW_SIZE; r++) begin
      for (int unsigned c = 0; c < WINDOW_SIZE; c++) begin
        if (c < WINDOW_SIZE - 1) win_next[r*WINDOW_SIZE+c] = win_q[r*WINDOW_SIZE+c+1];
        else                     win_next[r*WINDOW_SIZE+c] = col_vec[r];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state <= IDLE;
      col   <= '0;
      row   <= '0;
    end else begin
      state <= state_next;
      col   <= col_next;
      row   <= row_next;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      frame_err_o  <= 1'b0;
      s1_valid     <= 1'b0;
      s1_emit      <= 1'b0;
      s1_col       <= '0;
      s1_pix       <= '0;
      win_q        <= '0;
      data_valid_o <= 1'b0;
      data_o       <= '0;
    end else begin
      frame_err_o  <= err_next;
      s1_valid     <= accept;
      s1_emit      <= emit0;
      if (accept) begin
        s1_col <= pix_col;
        s1_pix <= data_i;
      end
      data_valid_o <= s1_valid && s1_emit;
      if (s1_valid) begin
        win_q <= win_next;
        if (s1_emit) data_o <= win_next;
      end
    end
  end

endmodule

// File: tb/tb_window_generator.sv
// Self-checking bench: a frame-level model schedules expected windows per cycle;
// literal windows pin the model for each directed scenario.
module tb_window_generator;

  localparam int unsigned PW   = 12;
  localparam int unsigned WS   = 3;
  localparam int unsigned FW   = 4;
  localparam int unsigned FH   = 4;
  localparam int unsigned NI   = WS * WS;
  localparam int unsigned MAXC = 4096;

  logic clk = 1'b0;
  logic rst_i = 1'b0;
  logic data_valid_i = 1'b0;
  logic sof_i = 1'b0;
  logic [PW-1:0] data_i = '0;
  logic data_valid_o;
  logic frame_err_o;
  logic [NI-1:0][PW-1:0] data_o;

  window_generator #(
    .PIX_DATA_W   (PW),
    .WINDOW_SIZE  (WS),
    .FRAME_WIDTH  (FW),
    .FRAME_HEIGHT (FH)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .data_valid_i (data_valid_i),
    .sof_i        (sof_i),
    .data_i       (data_i),
    .data_valid_o (data_valid_o),
    .data_o       (data_o),
    .frame_err_o  (frame_err_o)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  // expectations scheduled by observation cycle
  bit              exp_v   [MAXC];
  bit              exp_err [MAXC];
  bit              exp_rst [MAXC];
  logic [NI*PW-1:0] exp_w  [MAXC];
  logic [NI*PW-1:0] held = '0;

  int n_cmp = 0;
  int n_bad = 0;

  bit          in_frame = 1'b0;
  int unsigned pos = 0;
  int unsigned img [FH][FW];
  int unsigned last_drive_cyc;

  logic [NI*PW-1:0] got_q [$];
  int unsigned      got_cyc [$];
  int unsigned      comp_q [$];
  int unsigned      err_cnt = 0;

  int unsigned lit [4][9] = '{
    '{0, 1, 2, 4, 5, 6,  8,  9, 10},
    '{1, 2, 3, 5, 6, 7,  9, 10, 11},
    '{4, 5, 6, 8, 9, 10, 12, 13, 14},
    '{5, 6, 7, 9, 10, 11, 13, 14, 15}
  };

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic logic [NI*PW-1:0] lit_pack(input int unsigned k, input int unsigned base);
    logic [NI*PW-1:0] v;
    for (int unsigned i = 0; i < NI; i++) v[i*PW +: PW] = PW'(lit[k][i] + base);
    return v;
  endfunction

  always @(negedge clk) begin
    if (cyc >= MAXC - 4) begin
      $display("FAIL watchdog: cycle %0d reached limit %0d", cyc, MAXC - 4);
      $fatal(1);
    end
    if (cyc >= 1) begin
      if (exp_rst[cyc]) held = '0;
      if (exp_v[cyc])   held = exp_w[cyc];
      chk("data_valid_o", 128'(data_valid_o), 128'(exp_v[cyc]));
      chk("frame_err_o",  128'(frame_err_o),  128'(exp_err[cyc]));
      chk("data_o",       128'(data_o),       128'(held));
      if (data_valid_o === 1'b1) begin
        got_q.push_back(data_o);
        got_cyc.push_back(cyc);
      end
      if (frame_err_o === 1'b1) err_cnt++;
    end
  end

  task automatic drive(input bit v, input bit s, input int unsigned d);
    int unsigned n, r, c;
    logic [NI*PW-1:0] w;
    @(posedge clk);
    #1;
    rst_i = 1'b1;
    data_valid_i = v;
    sof_i = s;
    data_i = PW'(d);
    n = cyc;
    last_drive_cyc = n;
    if (v && (s || in_frame)) begin
      if (s) begin
        if (in_frame) exp_err[n+1] = 1'b1;
        in_frame = 1'b1;
        pos = 0;
      end
      r = pos / FW;
      c = pos % FW;
      img[r][c] = d;
      if (r >= WS - 1 && c >= WS - 1) begin
        for (int unsigned rr = 0; rr < WS; rr++)
          for (int unsigned cc = 0; cc < WS; cc++)
            w[(rr*WS+cc)*PW +: PW] = PW'(img[r-(WS-1)+rr][c-(WS-1)+cc]);
        exp_v[n+2] = 1'b1;
        exp_w[n+2] = w;
      end
      pos++;
      if (pos == FW * FH) in_frame = 1'b0;
    end else if (v) begin
      exp_err[n+1] = 1'b1;
    end
  endtask

  task automatic do_reset();
    int unsigned n;
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    data_valid_i = 1'b0;
    sof_i = 1'b0;
    n = cyc;
    exp_rst[n+1] = 1'b1;
    exp_v[n+1]   = 1'b0;
    exp_v[n+2]   = 1'b0;
    exp_err[n+1] = 1'b0;
    in_frame = 1'b0;
  endtask

  task automatic idle(input int unsigned k);
    repeat (k) drive(1'b0, 1'b0, 0);
  endtask

  task automatic frame(input int unsigned base, input bit gaps);
    for (int unsigned i = 0; i < FW * FH; i++) begin
      drive(1'b1, i == 0, base + i);
      if ((i % FW) >= WS - 1 && (i / FW) >= WS - 1) comp_q.push_back(last_drive_cyc);
      if (gaps) idle(i < 8 ? 1 : $urandom_range(5, 1));
    end
  endtask

  task automatic clear_cap();
    got_q.delete();
    got_cyc.delete();
    comp_q.delete();
    err_cnt = 0;
  endtask

  task automatic check_windows(input string tag, input int unsigned base0,
                               input int unsigned base1, input int unsigned n);
    chk($sformatf("%s count", tag), 128'(got_q.size()), 128'(n));
    for (int unsigned k = 0; k < n; k++) begin
      if (k < got_q.size()) begin
        chk($sformatf("%s win%0d", tag, k), 128'(got_q[k]),
            128'(lit_pack(k % 4, k < 4 ? base0 : base1)));
        if (k < comp_q.size())
          chk($sformatf("%s lat%0d", tag, k), 128'(got_cyc[k]), 128'(comp_q[k] + 2));
      end
    end
  endtask

  initial begin
    int unsigned sum;
    exp_rst[1] = 1'b1;
    repeat (3) do_reset();
    idle(2);

    // basic continuous frame
    clear_cap();
    frame(0, 1'b0);
    idle(4);
    check_windows("basic", 0, 0, 4);
    if (got_q.size() > 0) begin
      sum = 0;
      for (int unsigned i = 0; i < NI; i++) sum += int'(got_q[0][i*PW +: PW]);
      chk("basic mean", 128'(sum / NI), 128'(5));
    end
    chk("basic err", 128'(err_cnt), 128'(0));

    // gapped frame
    clear_cap();
    frame(0, 1'b1);
    idle(4);
    check_windows("gaps", 0, 0, 4);

    // orphan pixel in IDLE
    clear_cap();
    drive(1'b1, 1'b0, 12'hABC);
    idle(4);
    chk("orphan err", 128'(err_cnt), 128'(1));
    chk("orphan wins", 128'(got_q.size()), 128'(0));
    clear_cap();
    frame(0, 1'b0);
    idle(4);
    check_windows("after_orphan", 0, 0, 4);

    // early restart at pixel index 7
    clear_cap();
    for (int unsigned i = 0; i < 7; i++) drive(1'b1, i == 0, i);
    frame(100, 1'b0);
    idle(4);
    chk("restart err", 128'(err_cnt), 128'(1));
    check_windows("restart", 100, 100, 4);

    // mid-frame reset after pixel 9
    clear_cap();
    for (int unsigned i = 0; i < 10; i++) drive(1'b1, i == 0, i + 50);
    do_reset();
    drive(1'b0, 1'b0, 0);
    #3;
    chk("rst valid", 128'(data_valid_o), 128'(0));
    chk("rst data", 128'(data_o), 128'(0));
    frame(0, 1'b0);
    idle(4);
    check_windows("post_reset", 0, 0, 4);

    // back-to-back frames
    clear_cap();
    frame(0, 1'b0);
    frame(16, 1'b0);
    idle(4);
    check_windows("b2b", 0, 16, 8);
    chk("b2b err", 128'(err_cnt), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
